fb_write_buffer: RTL and testbench

FB_WRITE_BUFFER -- requirements
Module: fb_write_buffer

---
 rtl/fb_write_buffer.sv | 179 +++++++++++++++++
 tb/tb_fb_write_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_buffer.sv
// fb_write_buffer: posted-write buffer between a pixel writer and a DDRAM port.
// Requests are queued in a circular FIFO. Back-to-back writes to the same word
// are merged into the tail entry. A single output register drives the DDRAM
// bus and holds its contents while the memory stalls.
module fb_write_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 29
) (
    input  logic                     CLK_VIDEO,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [AW-1:0]            addr,
    input  logic [63:0]              din,
    input  logic [7:0]               be,
    input  logic                     clr_ovf,
    input  logic                     DDRAM_BUSY,
    output logic                     DDRAM_WE,
    output logic [AW-1:0]            DDRAM_ADDR,
    output logic [63:0]              DDRAM_DIN,
    output logic [7:0]               DDRAM_BE,
    output logic [7:0]               DDRAM_BURSTCNT,
    output logic                     DDRAM_RD,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     overflow
);

    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW:0]   L_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]   L_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   L_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] P_ONE  = {{(PW-1){1'b0}}, 1'b1};

    // FIFO storage; entries are only meaningful between r_rptr and r_wptr
    logic [AW-1:0] r_mem_addr [DEPTH];
    logic [63:0]   r_mem_din  [DEPTH];
    logic [7:0]    r_mem_be   [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_level;

    // Output register driving the DDRAM bus
    logic          r_we;
    logic [AW-1:0] r_oaddr;
    logic [63:0]   r_odin;
    logic [7:0]    r_obe;

    logic          r_ovf;
    logic          r_empty;

    logic          w_out_free;
    logic          w_pop;
    logic [PW-1:0] w_tail;
    logic          w_tail_stays;
    logic          w_merge;
    logic          w_fresh;
    logic          w_bypass;
    logic          w_push;
    logic          w_drop;
    logic [PW:0]   w_level_nxt;
    logic          w_we_nxt;

    // Byte-lane merge: lanes with sel set take the new data, others keep the old
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_d,
                                                input logic [63:0] new_d,
                                                input logic [7:0]  sel);
        logic [63:0] res;
        res = old_d;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_d[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_d[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Request classification: pop, merge, bypass, push or drop for this cycle
    always_comb begin
        w_out_free   = (!r_we) || (!DDRAM_BUSY);
        w_pop        = w_out_free && (r_level != L_ZERO);
        w_tail       = r_wptr - P_ONE;
        // The tail can only absorb a merge if it is not leaving the FIFO now
        w_tail_stays = (r_level > L_ONE) || ((r_level == L_ONE) && !w_pop);
        w_merge      = wr && w_tail_stays && (r_mem_addr[w_tail] == addr);
        w_fresh      = wr && !w_merge;
        w_bypass     = w_fresh && (r_level == L_ZERO) && w_out_free;
        w_push       = w_fresh && !w_bypass && (r_level != L_FULL);
        // A full FIFO drops new requests even if a pop frees a slot this cycle
        w_drop       = w_fresh && (r_level == L_FULL);

        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + L_ONE;
            2'b01:   w_level_nxt = r_level - L_ONE;
            default: w_level_nxt = r_level;
        endcase

        if (w_out_free) begin
            if (w_pop) begin
                w_we_nxt = 1'b1;
            end else if (w_bypass) begin
                w_we_nxt = 1'b1;
            end else begin
                w_we_nxt = 1'b0;
            end
        end else begin
            w_we_nxt = r_we;
        end
    end

    // Control state: pointers, occupancy, output register and status flags
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_level <= L_ZERO;
            r_we    <= 1'b0;
            r_oaddr <= {AW{1'b0}};
            r_odin  <= 64'h0;
            r_obe   <= 8'h00;
            r_ovf   <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + P_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_ONE;
            end
            r_level <= w_level_nxt;
            r_we    <= w_we_nxt;
            // Address/data/enables only change when the bus is free, so a
            // stalled transfer keeps its values
            if (w_pop) begin
                r_oaddr <= r_mem_addr[r_rptr];
                r_odin  <= r_mem_din[r_rptr];
                r_obe   <= r_mem_be[r_rptr];
            end else if (w_bypass) begin
                r_oaddr <= addr;
                r_odin  <= din;
                r_obe   <= be;
            end
            // A drop wins over a simultaneous clear so no loss goes unseen
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
            r_empty <= (w_level_nxt == L_ZERO) && !w_we_nxt;
        end
    end

    // FIFO storage write: new entry at the tail, or in-place merge into it
    always_ff @(posedge CLK_VIDEO) begin
        if (!reset) begin
            if (w_push) begin
                r_mem_addr[r_wptr] <= addr;
                r_mem_din[r_wptr]  <= din;
                r_mem_be[r_wptr]   <= be;
            end else if (w_merge) begin
                r_mem_din[w_tail] <= merge_bytes(r_mem_din[w_tail], din, be);
                r_mem_be[w_tail]  <= r_mem_be[w_tail] | be;
            end
        end
    end

    assign DDRAM_WE       = r_we;
    assign DDRAM_ADDR     = r_oaddr;
    assign DDRAM_DIN      = r_odin;
    assign DDRAM_BE       = r_obe;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = 1'b0;
    assign level          = r_level;
    assign empty          = r_empty;
    assign overflow       = r_ovf;

endmodule

// File: tb/tb_fb_write_buffer.sv
// tb_fb_write_buffer: directed checks of the DDRAM write buffer.
module tb_fb_write_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 29;

    logic          CLK_VIDEO;
    logic          reset;
    logic          wr;
    logic [AW-1:0] addr;
    logic [63:0]   din;
    logic [7:0]    be;
    logic          clr_ovf;
    logic          DDRAM_BUSY;
    logic          DDRAM_WE;
    logic [AW-1:0] DDRAM_ADDR;
    logic [63:0]   DDRAM_DIN;
    logic [7:0]    DDRAM_BE;
    logic [7:0]    DDRAM_BURSTCNT;
    logic          DDRAM_RD;
    logic [4:0]    level;
    logic          empty;
    logic          overflow;

    int n_tests;
    int n_fail;
    int tx;
    int rx;

    logic [AW-1:0] hold_addr;
    logic [63:0]   hold_din;
    logic [7:0]    hold_be;

    fb_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK_VIDEO      (CLK_VIDEO),
        .reset          (reset),
        .wr             (wr),
        .addr           (addr),
        .din            (din),
        .be             (be),
        .clr_ovf        (clr_ovf),
        .DDRAM_BUSY     (DDRAM_BUSY),
        .DDRAM_WE       (DDRAM_WE),
        .DDRAM_ADDR     (DDRAM_ADDR),
        .DDRAM_DIN      (DDRAM_DIN),
        .DDRAM_BE       (DDRAM_BE),
        .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
        .DDRAM_RD       (DDRAM_RD),
        .level          (level),
        .empty          (empty),
        .overflow       (overflow)
    );

    initial CLK_VIDEO = 1'b0;
    always #5 CLK_VIDEO = ~CLK_VIDEO;

    task automatic tick();
        @(posedge CLK_VIDEO);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ovf_din(input int i);
        return {56'hA5A5A5A5A5A5A5, 8'(i)};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; wr = 1'b0; addr = '0; din = 64'h0; be = 8'h00;
        clr_ovf = 1'b0; DDRAM_BUSY = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_we",    64'(DDRAM_WE),       64'h0);
        chk("rst_level", 64'(level),          64'h0);
        chk("rst_empty", 64'(empty),          64'h1);
        chk("rst_ovf",   64'(overflow),       64'h0);
        chk("rst_addr",  64'(DDRAM_ADDR),     64'h0);
        chk("rst_din",   DDRAM_DIN,           64'h0);
        chk("rst_be",    64'(DDRAM_BE),       64'h0);
        chk("burstcnt",  64'(DDRAM_BURSTCNT), 64'h1);
        chk("rd",        64'(DDRAM_RD),       64'h0);

        // Idle bypass
        wr = 1'b1; addr = 29'h100; din = 64'hDEADBEEF_CAFEF00D; be = 8'h0F;
        tick();
        wr = 1'b0;
        chk("byp_we",    64'(DDRAM_WE),   64'h1);
        chk("byp_addr",  64'(DDRAM_ADDR), 64'h100);
        chk("byp_be",    64'(DDRAM_BE),   64'h0F);
        chk("byp_din",   DDRAM_DIN,       64'hDEADBEEF_CAFEF00D);
        chk("byp_level", 64'(level),      64'h0);
        chk("byp_empty", 64'(empty),      64'h0);
        tick();
        chk("byp_we_off", 64'(DDRAM_WE), 64'h0);
        chk("byp_empty2", 64'(empty),    64'h1);

        // Merge into the tail entry while the bus is stalled
        DDRAM_BUSY = 1'b1;
        wr = 1'b1; addr = 29'h10; din = 64'hAAAAAAAA_AAAAAAAA; be = 8'h0F;
        tick();
        addr = 29'h20; din = 64'h11111111_11111111; be = 8'h0F;
        tick();
        addr = 29'h20; din = 64'h22222222_22222222; be = 8'hF0;
        tick();
        wr = 1'b0;
        chk("mrg_level", 64'(level),      64'h1);
        chk("mrg_we",    64'(DDRAM_WE),   64'h1);
        chk("mrg_addr0", 64'(DDRAM_ADDR), 64'h10);
        DDRAM_BUSY = 1'b0;
        tick();
        chk("mrg_addr1", 64'(DDRAM_ADDR), 64'h20);
        chk("mrg_we1",   64'(DDRAM_WE),   64'h1);
        chk("mrg_be1",   64'(DDRAM_BE),   64'hFF);
        chk("mrg_din1",  DDRAM_DIN,       64'h22222222_11111111);
        chk("mrg_lvl0",  64'(level),      64'h0);
        tick();
        chk("mrg_done",  64'(DDRAM_WE),   64'h0);
        chk("mrg_empty", 64'(empty),      64'h1);

        // Stall hold for ten cycles
        wr = 1'b1; addr = 29'h55; din = 64'h01234567_89ABCDEF; be = 8'h3C;
        tick();
        wr = 1'b0;
        hold_addr = 29'h55; hold_din = 64'h01234567_89ABCDEF; hold_be = 8'h3C;
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_we",   64'(DDRAM_WE),   64'h1);
            chk("hold_addr", 64'(DDRAM_ADDR), 64'(hold_addr));
            chk("hold_din",  DDRAM_DIN,       hold_din);
            chk("hold_be",   64'(DDRAM_BE),   64'(hold_be));
        end
        DDRAM_BUSY = 1'b0;
        tick();
        chk("hold_done",  64'(DDRAM_WE), 64'h0);
        chk("hold_empty", 64'(empty),    64'h1);

        // Overflow: one in the output register, sixteen queued, one dropped
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr = 1'b1; addr = AW'(32'h200 + i); din = ovf_din(i); be = 8'hFF;
            tick();
        end
        wr = 1'b0;
        chk("ovf_level", 64'(level),      64'd16);
        chk("ovf_flag",  64'(overflow),   64'h1);
        chk("ovf_head",  64'(DDRAM_ADDR), 64'h200);
        // Drop together with a clear keeps the flag set
        wr = 1'b1; addr = 29'h300; din = 64'h0; be = 8'hFF; clr_ovf = 1'b1;
        tick();
        wr = 1'b0;
        chk("ovf_drop_clr", 64'(overflow), 64'h1);
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr",   64'(overflow), 64'h0);
        // A merge into the tail is accepted even when full
        wr = 1'b1; addr = 29'h210; din = 64'h00000000_000000FF; be = 8'h01;
        tick();
        wr = 1'b0;
        chk("full_merge_lvl", 64'(level),    64'd16);
        chk("full_merge_ovf", 64'(overflow), 64'h0);
        DDRAM_BUSY = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("drain_we",   64'(DDRAM_WE),   64'h1);
            chk("drain_addr", 64'(DDRAM_ADDR), 64'(32'h200 + k));
            chk("drain_din",  DDRAM_DIN,       (k == 16) ? {56'hA5A5A5A5A5A5A5, 8'hFF} : ovf_din(k));
        end
        tick();
        chk("drain_done",  64'(DDRAM_WE), 64'h0);
        chk("drain_empty", 64'(empty),    64'h1);

        // Pointer wrap with random stalls
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 2000 && rx < 40; cyc++) begin
            DDRAM_BUSY = ($urandom_range(2, 0) == 0);
            if (tx < 40 && (cyc % 2) == 0 && level < 5'd14) begin
                wr = 1'b1; addr = AW'(32'h1000 + tx); din = 64'(tx); be = 8'hFF;
            end else begin
                wr = 1'b0;
            end
            if (DDRAM_WE && !DDRAM_BUSY) begin
                chk("wrap_order", 64'(DDRAM_ADDR), 64'(32'h1000 + rx));
                rx++;
            end
            tick();
            if (wr) begin
                tx++;
            end
        end
        wr = 1'b0;
        DDRAM_BUSY = 1'b0;
        chk("wrap_count", 64'(rx),       64'd40);
        chk("wrap_extra", 64'(DDRAM_WE), 64'h0);
        chk("wrap_ovf",   64'(overflow), 64'h0);
        tick();
        chk("wrap_empty", 64'(empty),    64'h1);

        // Reset in the middle of a stalled stream
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; addr = AW'(32'h400 + i); din = 64'(i); be = 8'hFF;
            tick();
        end
        chk("rs_level", 64'(level), 64'd5);
        reset = 1'b1;
        wr = 1'b1; addr = 29'h500; din = 64'h5; be = 8'hFF;
        tick();
        chk("rs_we",    64'(DDRAM_WE),   64'h0);
        chk("rs_level0", 64'(level),     64'h0);
        chk("rs_empty", 64'(empty),      64'h1);
        chk("rs_addr",  64'(DDRAM_ADDR), 64'h0);
        reset = 1'b0;
        wr = 1'b0;
        DDRAM_BUSY = 1'b0;
        tick();
        chk("rs_after_we",    64'(DDRAM_WE), 64'h0);
        chk("rs_after_level", 64'(level),    64'h0);
        chk("rs_after_empty", 64'(empty),    64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
